mod_exp_32: RTL and testbench
=============================

// Module: mod_exp_32
// PURPOSE
//  Modular exponentiator: result = base^exp mod modulus, unsigned W-bit operands.
//  Left-to-right square-and-multiply over exp, MSB first. Every step goes through
//  one internal modular multiplier: a full product, then bit-serial restoring reduction.
//  Sits downstream of the multiply/divide arithmetic units; the RSA encrypt/decrypt datapath uses it.
// PARAMETERS
//  W   32   operand width (base, exp, modulus, result)
// PORTS
//  clk       in   1   clock, all logic on posedge
//  rst_n     in   1   synchronous active-low reset
//  start     in   1   1-cycle pulse; operands sampled when accepted
//  base      in   W   base (any value, also >= modulus)
//  exp       in   W   exponent
//  modulus   in   W   modulus n
//  result    out  W   base^exp mod n, valid while ready_n==0
//  ready_n   out  1   1 = busy/not valid, 0 = result valid
//  busy      out  1   1 while an operation is running
//  err       out  1   1 = modulus was 0, valid with ready_n==0
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): result=0, ready_n=1, busy=0, err=0, FSM->IDLE, mod_mul aborted.
//  Reset mid-operation aborts at once. No result is produced.
//  start is accepted in IDLE or DONE only. Ignored while busy.
//  On accept: latch base/exp/modulus, set ready_n=1, busy=1, err=0.
//  FSM: IDLE -> CHK -> PRE -> SQR -> [MUL] -> NEXT -> ... -> DONE
//   CHK : n==0 -> DONE with err=1, result=0. n==1 -> acc=0. Else acc=1. bit index i=W-1.
//   PRE : br = base mod n, computed as mod_mul(base,1).
//   SQR : acc = acc*acc mod n. If exp[i]==1 go to MUL, else go to NEXT.
//   MUL : acc = acc*br mod n.
//   NEXT: if i==0 go to DONE, else i=i-1 and go to SQR.
//   DONE: result=acc, ready_n=0, busy=0. Held until the next accepted start.
//  mod_mul op: full 2W-bit product p=a*b in the launch cycle.
//   Then 2W cycles, MSB first: r={r,p[k]}; if r>=n then r=r-n. r is W+1 bits wide.
//   Launch to done = 2W+2 cycles. The FSM spends 1 extra cycle per op: 2W+3 per op.
//  Latency, start accept to ready_n low: 2 + (1 + W + popcount(exp))*(2W+3).
//   W=32: 2213 + 67*popcount(exp).
//  Latency for n==0: 2 cycles (CHK -> DONE).
//  Invariant: acc < n always, so r never exceeds W+1 bits.
// CONFIGURATION
//  `MOD_EXP_SKIP_LZ_EN defined:
//   - CHK starts i at the MSB set bit of exp and skips its leading zeros.
//   - exp==0 skips SQR/MUL entirely: result = 1 mod n.
//   - Latency: 2 + (1 + msb(exp)+1 + popcount(exp))*(2W+3). msb(0)+1 = 0.
//   - The MSB search is a combinational priority encoder in CHK and adds no cycles.
//  Not defined: all W exponent bits are processed, with the exact latency above.
//  result and err are identical in both builds.
// STRUCTURE
//  Shared include rsa_defs.vh: RSA_W=32, FSM state localparams (3-bit encoding).
//  Sub-module mod_mul_w (a, b, n, start, done pulse, p): product plus reduction loop.
//  The top level is only the FSM, the exponent bit index, and the acc/br registers.
// TESTING
//  base=4, exp=13, n=497 -> result=445, err=0.
//   Without the macro, latency = 2213 + 3*67 = 2414 cycles.
//  base=2, exp=10, n=1000 -> result=24.
//  base=100, exp=1, n=7 -> result=2 (base >= n is pre-reduced).
//  base=0xFFFFFFFF, exp=2, n=0xFFFFFFFB -> result=16.
//  base=5, exp=0, n=7 -> result=1.
//   n=1 -> result=0. n=0 -> err=1, result=0, ready_n low after 2 cycles.
//  Reset and start edge cases:
//   - Pulse rst_n low mid-run -> ready_n=1, busy=0 the next cycle.
//   - A new start then gives the correct result.
//   - start while busy is ignored.

Source files
------------

// File: rtl/mod_exp_32_pkg.sv
// Shared definitions for the modular exponentiator: operand width and the
// state encodings of the exponent FSM and the modular multiplier.
package mod_exp_32_pkg;

  localparam int RSA_W = 32;

  // Exponent-level FSM. Advancing to the next exponent bit happens in the
  // same cycle the square/multiply result is consumed, so it has no state
  // of its own.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_PRE  = 3'd2,
    S_SQR  = 3'd3,
    S_MUL  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  // Modular multiplier: product capture, bit-serial reduction, done pulse.
  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_RED  = 2'd1,
    M_FIN  = 2'd2
  } mm_state_e;

endpackage

// File: rtl/mod_exp_32_mul.sv
// Modular multiplier p = a*b mod n. The full 2W-bit product is captured in
// the launch cycle, then reduced MSB first, one product bit per cycle, with a
// restoring subtract. done_o pulses 2W+2 cycles after the launch cycle.
module mod_exp_32_mul
  import mod_exp_32_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] n_i,
  output logic         done_o,
  output logic [W-1:0] p_o
);

  localparam int KW = $clog2(2 * W);

  mm_state_e       state_q, state_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [W-1:0]    n_q, n_d;
  logic [W-1:0]    r_q, r_d;
  logic [KW-1:0]   k_q, k_d;
  logic            done_q, done_d;
  logic [W:0]      r_shift;

  // State registers; reset abandons any reduction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= M_IDLE;
      prod_q  <= '0;
      n_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      n_q     <= n_d;
      r_q     <= r_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  // Next state: one restoring-reduction step per cycle. r stays below n, so
  // the shifted value needs only one extra bit and one subtract.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    n_d     = n_q;
    r_d     = r_q;
    k_d     = k_q;
    done_d  = 1'b0;
    r_shift = {r_q, prod_q[k_q]};

    case (state_q)
      M_IDLE: ;
      M_RED: begin
        if (r_shift >= {1'b0, n_q}) r_d = W'(r_shift - {1'b0, n_q});
        else                        r_d = W'(r_shift);
        if (k_q == '0) state_d = M_FIN;
        else           k_d     = k_q - 1'b1;
      end
      M_FIN: begin
        done_d  = 1'b1;
        state_d = M_IDLE;
      end
      default: state_d = M_IDLE;
    endcase

    if (start_i) begin
      prod_d  = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
      n_d     = n_i;
      r_d     = '0;
      k_d     = KW'(2 * W - 1);
      state_d = M_RED;
    end
  end

  assign done_o = done_q;
  assign p_o    = r_q;

endmodule

// File: rtl/mod_exp_32.sv
// Modular exponentiator: result = base^exp mod modulus, left-to-right
// square-and-multiply, every step through one shared modular multiplier.
// Optional build macro MOD_EXP_SKIP_LZ_EN: start at the exponent's highest set
// bit and skip the squarings of its leading zeros (exp==0 ends after the
// base pre-reduction). result and err are the same in both builds.
//
// Handshake: start is a one-cycle request honoured only when busy==0 (IDLE or
// DONE); operands are captured on that edge. ready_n==0 marks result/err as
// valid and they hold until the next accepted start.
module mod_exp_32
  import mod_exp_32_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] result,
  output logic         ready_n,
  output logic         busy,
  output logic         err
);

  localparam int IW = $clog2(W);

  state_e          state_q, state_d;
  logic [W-1:0]    base_q, base_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [W-1:0]    n_q, n_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    br_q, br_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            wait_q, wait_d;
  logic [W-1:0]    result_q, result_d;
  logic            ready_n_q, ready_n_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            mm_start, mm_done, advance;
  logic [W-1:0]    mm_a, mm_b, mm_p;
`ifdef MOD_EXP_SKIP_LZ_EN
  logic [IW-1:0]   msb_idx;
`endif

  mod_exp_32_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mm_start),
    .a_i     (mm_a),
    .b_i     (mm_b),
    .n_i     (n_q),
    .done_o  (mm_done),
    .p_o     (mm_p)
  );

  // State and datapath registers; reset aborts any running operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      exp_q     <= '0;
      n_q       <= '0;
      acc_q     <= '0;
      br_q      <= '0;
      idx_q     <= '0;
      wait_q    <= 1'b0;
      result_q  <= '0;
      ready_n_q <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      exp_q     <= exp_d;
      n_q       <= n_d;
      acc_q     <= acc_d;
      br_q      <= br_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      result_q  <= result_d;
      ready_n_q <= ready_n_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Next state and multiplier control. Each multiplier step spends one cycle
  // launching (wait_q low) and then waits for the done pulse.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    exp_d     = exp_q;
    n_d       = n_q;
    acc_d     = acc_q;
    br_d      = br_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    result_d  = result_q;
    ready_n_d = ready_n_q;
    busy_d    = busy_q;
    err_d     = err_q;
    mm_start  = 1'b0;
    mm_a      = acc_q;
    mm_b      = acc_q;
    advance   = 1'b0;
`ifdef MOD_EXP_SKIP_LZ_EN
    msb_idx = '0;
    for (int j = 0; j < W; j++) begin
      if (exp_q[j]) msb_idx = IW'(j);
    end
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          result_d  = acc_q;
          ready_n_d = 1'b0;
          busy_d    = 1'b0;
        end
        if (start) begin
          base_d    = base;
          exp_d     = exp;
          n_d       = modulus;
          ready_n_d = 1'b1;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          state_d   = S_CHK;
        end
      end
      S_CHK: begin
        wait_d = 1'b0;
        if (n_q == '0) begin
          err_d   = 1'b1;
          acc_d   = '0;
          state_d = S_DONE;
        end else begin
          // 1 mod n: zero when n==1, otherwise one.
          acc_d   = (n_q == W'(1)) ? '0 : W'(1);
`ifdef MOD_EXP_SKIP_LZ_EN
          idx_d   = msb_idx;
`else
          idx_d   = IW'(W - 1);
`endif
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        mm_a = base_q;
        mm_b = W'(1);
        if (!wait_q) begin
          mm_start = 1'b1;
          wait_d   = 1'b1;
        end else if (mm_done) begin
          br_d   = mm_p;
          wait_d = 1'b0;
`ifdef MOD_EXP_SKIP_LZ_EN
          state_d = (exp_q == '0) ? S_DONE : S_SQR;
`else
          state_d = S_SQR;
`endif
        end
      end
      S_SQR: begin
        if (!wait_q) begin
          mm_start = 1'b1;
          wait_d   = 1'b1;
        end else if (mm_done) begin
          acc_d  = mm_p;
          wait_d = 1'b0;
          if (exp_q[idx_q]) state_d = S_MUL;
          else              advance = 1'b1;
        end
      end
      S_MUL: begin
        mm_b = br_q;
        if (!wait_q) begin
          mm_start = 1'b1;
          wait_d   = 1'b1;
        end else if (mm_done) begin
          acc_d   = mm_p;
          wait_d  = 1'b0;
          advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Move to the next lower exponent bit, or finish after bit 0.
    if (advance) begin
      if (idx_q == '0) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q - 1'b1;
        state_d = S_SQR;
      end
    end
  end

  assign result  = result_q;
  assign ready_n = ready_n_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mod_exp_32.sv
// Bench for mod_exp_32: directed and random operands against a right-to-left
// exponentiation model with a closed-form latency expectation.
module tb_mod_exp_32;

  localparam int W     = 32;
  localparam int LIMIT = 5000;

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic [W-1:0] n;
    logic [W-1:0] r;
    logic         er;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exp;
  logic [W-1:0] modulus;
  logic [W-1:0] result;
  logic         ready_n;
  logic         busy;
  logic         err;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  vec_t         dir_tab[7];

  // Clock and DUT
  always #5 clk = ~clk;

  mod_exp_32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base    (base),
    .exp     (exp),
    .modulus (modulus),
    .result  (result),
    .ready_n (ready_n),
    .busy    (busy),
    .err     (err)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", tag, got, got, want, want);
    end
  endtask

  // Reference: right-to-left binary exponentiation on 64-bit integers.
  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                               input logic [W-1:0] n);
    longint unsigned m, r, x;
    if (n == '0) return '0;
    m = longint'(n);
    r = 1 % m;
    x = longint'(b) % m;
    for (int j = 0; j < W; j++) begin
      if (e[j]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return W'(r);
  endfunction

  function automatic int ref_latency(input logic [W-1:0] e, input logic [W-1:0] n);
    int bits;
    if (n == '0) return 2;
`ifdef MOD_EXP_SKIP_LZ_EN
    bits = 0;
    for (int j = 0; j < W; j++) if (e[j]) bits = j + 1;
`else
    bits = W;
`endif
    return 2 + (1 + bits + $countones(e)) * (2 * W + 3);
  endfunction

  // Driver: one operation, optional ignored start at cycle `intrude` (0 = none).
  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                        input logic [W-1:0] want_res, input logic want_err, input int intrude);
    int lat_want;
    int k;
    bit seen;
    logic [W-1:0] want;
    lat_want = ref_latency(e, n);
    exp_q.push_back(want_res);
    @(negedge clk);
    base = b; exp = e; modulus = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = $urandom; exp = $urandom; modulus = $urandom;
    check_eq("ready_n_after_start", ready_n, 1);
    check_eq("busy_after_start", busy, 1);
    k = 0;
    seen = 0;
    while (k < LIMIT && !seen) begin
      @(posedge clk); #1;
      k++;
      if (k == intrude) begin
        start = 1'b1; base = $urandom; exp = $urandom; modulus = $urandom_range(2, 50);
      end else begin
        start = 1'b0;
      end
      if (!ready_n) seen = 1;
    end
    start = 1'b0;
    want = exp_q.pop_front();
    if (!seen) begin
      check_eq("timeout_ready_n", ready_n, 0);
    end else begin
      check_eq("result", result, want);
      check_eq("err", err, want_err);
      check_eq("latency", k, lat_want);
      check_eq("busy_done", busy, 0);
    end
  endtask

  initial begin
    logic [W-1:0] rb, re, rn;

    dir_tab[0] = '{32'd4,          32'd13,         32'd497,        32'd445, 1'b0};
    dir_tab[1] = '{32'd2,          32'd10,         32'd1000,       32'd24,  1'b0};
    dir_tab[2] = '{32'd100,        32'd1,          32'd7,          32'd2,   1'b0};
    dir_tab[3] = '{32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFB,  32'd16,  1'b0};
    dir_tab[4] = '{32'd5,          32'd0,          32'd7,          32'd1,   1'b0};
    dir_tab[5] = '{32'd7,          32'd5,          32'd1,          32'd0,   1'b0};
    dir_tab[6] = '{32'd123,        32'd456,        32'd0,          32'd0,   1'b1};

    // Reset block
    rst_n = 1'b0; start = 1'b0; base = '0; exp = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_result", result, 0);
    check_eq("reset_ready_n", ready_n, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_err", err, 0);
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors
    foreach (dir_tab[i])
      run_op(dir_tab[i].b, dir_tab[i].e, dir_tab[i].n, dir_tab[i].r, dir_tab[i].er, 0);

    // start while busy must be ignored
    run_op(32'd2, 32'd10, 32'd1000, 32'd24, 1'b0, 200);

    // Reset in the middle of an operation
    @(negedge clk);
    base = 32'd4; exp = 32'd13; modulus = 32'd497; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_ready_n", ready_n, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_rst_no_result", ready_n, 1);
    run_op(32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 0);

    // Random operands
    for (int i = 0; i < 6; i++) begin
      rb = $urandom;
      re = $urandom;
      rn = (i % 2 == 0) ? $urandom : $urandom_range(2, 1000);
      run_op(rb, re, rn, ref_modexp(rb, re, rn), rn == '0, (i == 3) ? 150 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
